// File: rtl/intr_ctrl.sv
// Interrupt controller: INTR synchronizer, pending latch and handshake FSM.
// Define INTR_EDGE_EN for edge-triggered PEND; the default is level-sensitive.
module intr_ctrl (
    input  logic CLK,
    input  logic RST_N,
    input  logic INTR,
    input  logic SEI,
    input  logic CLI,
    input  logic INTR_ACK,
    input  logic RETIE,
    output logic INTR_REQ,
    output logic I_FLG,
    output logic FLG_SHAD_LD,
    output logic FLG_LD_SEL,
    output logic FLG_C_LD,
    output logic FLG_Z_LD,
    output logic IN_ISR
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SAVE,
        SERVICE,
        RESTORE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic intr_m;
    logic intr_s;
    logic pend;
    logic pend_nxt;
    logic i_flg_nxt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            intr_m <= 1'b0;
            intr_s <= 1'b0;
        end else begin
            intr_m <= INTR;
            intr_s <= intr_m;
        end
    end

`ifdef INTR_EDGE_EN
    logic intr_s_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            intr_s_q <= 1'b0;
        end else begin
            intr_s_q <= intr_s;
        end
    end

    // a fresh rise beats the clear issued in SAVE
    always_comb begin
        pend_nxt = pend;
        if (intr_s && !intr_s_q) begin
            pend_nxt = 1'b1;
        end else if (state == SAVE) begin
            pend_nxt = 1'b0;
        end
    end
`else
    always_comb begin
        pend_nxt = intr_s;
    end
`endif

    always_comb begin
        i_flg_nxt = I_FLG;
        if (state == SAVE) begin
            i_flg_nxt = 1'b0;
        end else if (state == RESTORE) begin
            i_flg_nxt = 1'b1;
        end else if (CLI) begin
            i_flg_nxt = 1'b0;
        end else if (SEI) begin
            i_flg_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            pend  <= 1'b0;
            I_FLG <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            I_FLG <= i_flg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pend && I_FLG) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (INTR_ACK) begin
                    state_nxt = SAVE;
                end else if (CLI) begin
                    state_nxt = IDLE;
                end
            end
            SAVE: begin
                state_nxt = SERVICE;
            end
            SERVICE: begin
                if (RETIE) begin
                    state_nxt = RESTORE;
                end
            end
            RESTORE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        INTR_REQ    = 1'b0;
        FLG_SHAD_LD = 1'b0;
        FLG_LD_SEL  = 1'b0;
        FLG_C_LD    = 1'b0;
        FLG_Z_LD    = 1'b0;
        IN_ISR      = 1'b0;
        unique case (state)
            REQ: begin
                INTR_REQ = 1'b1;
            end
            SAVE: begin
                FLG_SHAD_LD = 1'b1;
            end
            SERVICE: begin
                IN_ISR = 1'b1;
            end
            RESTORE: begin
                FLG_LD_SEL = 1'b1;
                FLG_C_LD   = 1'b1;
                FLG_Z_LD   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed lifecycle scenarios then random traffic,
// every cycle compared against a behavioural model of the interrupt rules.
module tb_intr_ctrl;

    logic CLK = 1'b0;
    logic RST_N, INTR, SEI, CLI, INTR_ACK, RETIE;
    logic INTR_REQ, I_FLG, FLG_SHAD_LD, FLG_LD_SEL;
    logic FLG_C_LD, FLG_Z_LD, IN_ISR;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    intr_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .SEI(SEI),
        .CLI(CLI), .INTR_ACK(INTR_ACK), .RETIE(RETIE),
        .INTR_REQ(INTR_REQ), .I_FLG(I_FLG),
        .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_LD_SEL(FLG_LD_SEL),
        .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .IN_ISR(IN_ISR)
    );

    // lifecycle phase: 0 idle, 1 requesting, 2 saving, 3 in isr, 4 restoring
    int phase = 0;
    bit m_ie = 0;
    bit m_pend = 0;
    bit seen [3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit i, input bit s,
                              input bit c, input bit a, input bit t);
        bit sync_now, sync_old, new_pend, new_ie;
        int new_ph;
        if (!r) begin
            phase = 0;
            m_ie = 0;
            m_pend = 0;
            seen = '{0, 0, 0};
            return;
        end
        sync_now = seen[1];
        sync_old = seen[2];
`ifdef INTR_EDGE_EN
        if (sync_now && !sync_old) new_pend = 1;
        else if (phase == 2) new_pend = 0;
        else new_pend = m_pend;
`else
        new_pend = sync_now;
`endif
        if (phase == 2) new_ie = 0;
        else if (phase == 4) new_ie = 1;
        else if (c) new_ie = 0;
        else if (s) new_ie = 1;
        else new_ie = m_ie;
        case (phase)
            0: new_ph = (m_pend && m_ie) ? 1 : 0;
            1: new_ph = a ? 2 : (c ? 0 : 1);
            2: new_ph = 3;
            3: new_ph = t ? 4 : 3;
            default: new_ph = 0;
        endcase
        seen[2] = seen[1];
        seen[1] = seen[0];
        seen[0] = i;
        phase = new_ph;
        m_ie = new_ie;
        m_pend = new_pend;
    endtask

    task automatic step(input string tag, input bit r, input bit i,
                        input bit s, input bit c, input bit a, input bit t);
        logic [7:0] got, exp;
        RST_N = r; INTR = i; SEI = s; CLI = c; INTR_ACK = a; RETIE = t;
        @(posedge CLK);
        model_edge(r, i, s, c, a, t);
        #1;
        got = {1'b0, INTR_REQ, I_FLG, FLG_SHAD_LD, FLG_LD_SEL,
               FLG_C_LD, FLG_Z_LD, IN_ISR};
        exp = {1'b0, phase == 1, m_ie, phase == 2, phase == 4,
               phase == 4, phase == 4, phase == 3};
        check(tag, got, exp);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int lat;
        bit iv;
        @(negedge CLK);
        step("reset", 0, 0, 0, 0, 0, 0);
        step("reset", 0, 1, 1, 0, 1, 1);
        step("reset", 0, 0, 0, 0, 0, 0);
        step("sei", 1, 0, 1, 0, 0, 0);

        step("pulse", 1, 1, 0, 0, 0, 0);
        lat = 1;
        while (!INTR_REQ && lat < 10) begin
            step("latency_wait", 1, 0, 0, 0, 0, 0);
            lat++;
        end
        check("latency", 8'(lat), 8'd4);

        step("req_hold", 1, 0, 0, 0, 0, 0);
        step("ack", 1, 0, 0, 0, 1, 0);
        idle("service", 3);
        step("retie", 1, 0, 0, 0, 0, 1);
        idle("after_restore", 3);

        step("cli", 1, 0, 0, 1, 0, 0);
        step("masked_pulse", 1, 1, 0, 0, 0, 0);
        idle("masked_wait", 10);
        step("late_sei", 1, 0, 1, 0, 0, 0);
        idle("late_req", 3);
        step("ack2", 1, 0, 0, 0, 1, 0);
        idle("service2", 2);
        step("retie2", 1, 0, 0, 0, 0, 1);
        idle("idle2", 2);

        step("sei_cli", 1, 0, 1, 1, 0, 0);
        step("sei", 1, 0, 1, 0, 0, 0);
        step("pulse3", 1, 1, 0, 0, 0, 0);
        idle("wait3", 3);
        step("cli_in_req", 1, 0, 0, 1, 0, 0);
        idle("withdrawn", 2);
        step("sei_again", 1, 0, 1, 0, 0, 0);
        idle("rereq", 2);
        step("ack3", 1, 0, 0, 0, 1, 0);
        step("rst_in_save", 0, 0, 0, 0, 0, 0);
        idle("post_rst", 2);

        step("sei4", 1, 0, 1, 0, 0, 0);
        step("pulse4", 1, 1, 0, 0, 0, 0);
        idle("wait4", 3);
        step("ack4", 1, 0, 0, 0, 1, 0);
        step("svc4", 1, 0, 0, 0, 0, 0);
        step("pulse_in_isr", 1, 1, 0, 0, 0, 0);
        idle("svc4b", 4);
        step("retie4", 1, 0, 0, 0, 0, 1);
        idle("second_req", 4);
        step("ack5", 1, 0, 0, 0, 1, 0);
        step("rst_in_restore", 1, 0, 0, 0, 0, 1);
        step("restore_rst", 0, 0, 0, 0, 0, 0);
        idle("post_rst2", 2);

        iv = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3) == 0) iv = ~iv;
            step("random", $urandom_range(99) != 0, iv,
                 $urandom_range(5) == 0, $urandom_range(11) == 0,
                 $urandom_range(2) == 0, $urandom_range(4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have these ports:
  CLK        in   1  system clock; all state updates on rising edge
  RST_N      in   1  reset, synchronous, active-low
  INTR       in   1  external interrupt pin, asynchronous to CLK
  SEI        in   1  set-interrupt-enable strobe from control unit
  CLI        in   1  clear-interrupt-enable strobe from control unit
  INTR_ACK   in   1  control unit accepts pending interrupt
  RETIE      in   1  return-from-interrupt strobe from control unit
  INTR_REQ   out  1  interrupt request to control unit
  I_FLG      out  1  interrupt-enable flag
  FLG_SHAD_LD out 1  save C/Z into the FLAGS shadow registers
  FLG_LD_SEL out  1  select shadow C/Z as the FLAGS load source
  FLG_C_LD   out  1  load C flag
  FLG_Z_LD   out  1  load Z flag
  IN_ISR     out  1  high while the interrupt service routine runs

Function
REQ-002 INTR SHALL pass through a 2-flop synchronizer; INTR_S denotes the second-stage output.
REQ-003 FSM states SHALL be IDLE, REQ, SAVE, SERVICE and RESTORE; all outputs SHALL be Moore, decoded from registered state.
REQ-004 IDLE -> REQ SHALL occur when PEND=1 and I_FLG=1; otherwise the FSM SHALL stay in IDLE.
REQ-005 In REQ: INTR_REQ=1; INTR_ACK=1 -> SAVE; CLI=1 with INTR_ACK=0 -> IDLE (request withdrawn, PEND kept); INTR_ACK SHALL win over a simultaneous CLI.
REQ-006 SAVE SHALL last exactly 1 cycle: FLG_SHAD_LD=1, I_FLG cleared, PEND cleared, then -> SERVICE.
REQ-007 In SERVICE: IN_ISR=1; RETIE=1 -> RESTORE.
REQ-008 RESTORE SHALL last exactly 1 cycle: FLG_LD_SEL=1, FLG_C_LD=1, FLG_Z_LD=1, I_FLG set to 1, then -> IDLE.
REQ-009 Outside RESTORE, FLG_LD_SEL, FLG_C_LD and FLG_Z_LD SHALL be 0; outside SAVE, FLG_SHAD_LD SHALL be 0.
REQ-010 SEI SHALL set I_FLG and CLI SHALL clear I_FLG on the next edge; if both are high, CLI SHALL win; the SAVE clear and RESTORE set SHALL override SEI/CLI.
REQ-011 RETIE outside SERVICE, and INTR_ACK outside REQ, SHALL be ignored.
REQ-012 Latency SHALL be 4 edges from a clean INTR rise to INTR_REQ=1: 2 synchronizer, 1 PEND, 1 FSM.
REQ-013 An interrupt arriving during SAVE or SERVICE SHALL remain pending and SHALL be requested after RESTORE, provided I_FLG=1.

Reset
REQ-014 With RST_N=0 at a rising edge: state=IDLE, I_FLG=0, PEND=0, synchronizer flops=0; all outputs SHALL be 0 on the following cycle.
REQ-015 Reset SHALL take precedence in every state, including SAVE and RESTORE; no flag-load pulse SHALL be emitted after a reset edge.

Configuration
REQ-016 With INTR_EDGE_EN defined, PEND SHALL be set on a 0->1 transition of INTR_S, held until SAVE, and a set SHALL win over a simultaneous SAVE clear.
REQ-017 Without INTR_EDGE_EN, PEND SHALL equal INTR_S (level-sensitive), and SAVE SHALL have no effect on PEND.

Verification
REQ-018 Reset, SEI, 1-cycle INTR pulse (edge build) -> INTR_REQ=1 4 edges later, I_FLG=1.
REQ-019 In REQ, assert INTR_ACK 1 cycle -> FLG_SHAD_LD=1 exactly 1 cycle, I_FLG=0, IN_ISR=1 next cycle.
REQ-020 In SERVICE, RETIE 1 cycle -> FLG_LD_SEL=FLG_C_LD=FLG_Z_LD=1 for 1 cycle, I_FLG=1, state IDLE.
REQ-021 I_FLG=0 with INTR pulse -> no INTR_REQ; SEI 10 cycles later -> INTR_REQ=1 next cycle (edge build).
REQ-022 SEI and CLI same cycle -> I_FLG=0; CLI in REQ without ack -> INTR_REQ=0 next cycle, PEND=1.
REQ-023 RST_N=0 during SAVE -> FLG_SHAD_LD=0 after the edge, all outputs 0; INTR pulse in SERVICE -> second INTR_REQ after RESTORE.
